// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a valid/ready byte stream little-endian into
// words, writes them from address 0 upward and holds the CPU in reset until done.
module imem_loader #(
    parameter int  tam_entrada = 1024,
    parameter int  tam_salida  = 32,
    localparam int ADDR_W      = $clog2(tam_entrada),
    localparam int NB          = tam_salida / 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic [ADDR_W:0]       nwords,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [tam_salida-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);

    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [ADDR_W:0]   L_DEPTH    = (ADDR_W+1)'(tam_entrada);
    localparam logic [ADDR_W:0]   L_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] L_ADDR_ONE = ADDR_W'(1);
    localparam logic [IDX_W-1:0]  L_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  L_IDX_LAST = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_W:0]         r_nwords;
    logic [ADDR_W:0]         r_cnt;
    logic [ADDR_W-1:0]       r_addr;
    logic [IDX_W-1:0]        r_idx;
    logic [tam_salida-1:0]   r_data;
    logic                    r_error;

    logic                    w_start_seen;
    logic                    w_reject;
    logic                    w_load;
    logic                    w_xfer;
    logic [ADDR_W:0]         w_cnt_inc;
    logic                    w_last_word;

    assign w_cnt_inc   = r_cnt + L_CNT_ONE;
    assign w_last_word = (w_cnt_inc == r_nwords);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_start_seen = 1'b0;
        w_reject     = 1'b0;
        w_load       = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_start_seen = 1'b1;
                    if (nwords > L_DEPTH) begin
                        w_reject = 1'b1;
                        w_next   = S_IDLE;
                    end else if (nwords == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_load = 1'b1;
                        w_next = S_RECV;
                    end
                end
            end
            S_RECV: begin
                w_xfer = byte_valid;
                if (byte_valid && (r_idx == L_IDX_LAST)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = w_last_word ? S_DONE : S_RECV;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: command latch, byte packing, word/address bookkeeping
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_nwords <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_start_seen) begin
                r_error <= w_reject;
            end
            if (w_load) begin
                r_nwords <= nwords;
                r_cnt    <= '0;
                r_addr   <= '0;
                r_idx    <= '0;
            end
            if (w_xfer) begin
                for (int k = 0; k < NB; k++) begin
                    if (r_idx == IDX_W'(k)) begin
                        r_data[8*k +: 8] <= byte_in;
                    end
                end
                r_idx <= (r_idx == L_IDX_LAST) ? '0 : r_idx + L_IDX_ONE;
            end
            // Address only advances when another word follows, so a full-depth
            // load ends parked on the last location instead of wrapping.
            if (r_state == S_WRITE) begin
                r_cnt <= w_cnt_inc;
                if (!w_last_word) begin
                    r_addr <= r_addr + L_ADDR_ONE;
                end
            end
        end
    end

    assign byte_ready = (r_state == S_RECV);
    assign wr_en      = (r_state == S_WRITE);
    assign busy       = (r_state == S_RECV) || (r_state == S_WRITE);
    assign done       = (r_state == S_DONE);
    assign cpu_hold   = (r_state != S_DONE);
    assign error      = r_error;
    assign wr_addr    = r_addr;
    assign wr_data    = r_data;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes are rebuilt from the byte
// stream (word w = little-endian bytes 4w..4w+3 at address w) and compared.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int WW    = 32;
    localparam int NB    = WW / 8;
    localparam int AW    = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   nwords = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;

    imem_loader #(
        .tam_entrada(DEPTH),
        .tam_salida (WW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .nwords    (nwords),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: records every memory write and timing markers
    logic [63:0] got_q[$];
    int          wr_cyc_q[$];
    int          cyc = 0;
    int          n_overlap = 0;
    int          done_rise_cyc = -1;
    logic        prev_done = 1'b0;

    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (wr_en) begin
                got_q.push_back(64'({wr_addr, wr_data}));
                wr_cyc_q.push_back(cyc);
            end
            if (wr_en && byte_ready) n_overlap++;
            if (done && !prev_done) done_rise_cyc = cyc;
            prev_done = done;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] src_bytes[$];

    task automatic fill_random(input int nw);
        src_bytes.delete();
        for (int i = 0; i < nw * NB; i++) src_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_ctrl"}, 64'({byte_ready, wr_en, busy, done, error, cpu_hold}), 64'b000001);
        check_val({tag, "_addr"}, 64'(wr_addr), 64'd0);
        check_val({tag, "_data"}, 64'(wr_data), 64'd0);
    endtask

    // Streams src_bytes for an nw-word load; abort_after>=0 stops after that many bytes.
    task automatic run_load(input int nw, input int pct, input int poke_at, input int abort_after);
        int          total;
        int          idx;
        int          extra;
        int          budget;
        bit          xfer;
        bit          poked;
        logic [WW-1:0] word;
        logic [63:0] exp_q[$];
        total  = nw * NB;
        idx    = 0;
        extra  = 0;
        budget = total * 6 + 100;
        xfer   = 1'b0;
        poked  = 1'b0;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int k = 0; k < NB; k++) word = word | (WW'(src_bytes[w*NB + k]) << (8 * k));
            exp_q.push_back(64'({AW'(w), word}));
        end
        got_q.delete();
        wr_cyc_q.delete();
        done_rise_cyc = -1;
        @(negedge CLK);
        start  = 1'b1;
        nwords = (AW+1)'(nw);
        @(negedge CLK);
        start  = 1'b0;
        check_val("start_state", 64'({done, cpu_hold, busy}), 64'b011);
        while (budget > 0) begin
            if (xfer) begin
                if (idx < total) idx++;
                else extra++;
            end
            if (abort_after >= 0 && idx >= abort_after) begin
                byte_valid = 1'b0;
                start      = 1'b0;
                return;
            end
            if (done && idx == total) break;
            if (poke_at >= 0 && idx == poke_at && !poked) begin
                start  = 1'b1;
                nwords = (AW+1)'(1);
                poked  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (idx < total) begin
                byte_valid = (int'($urandom_range(0, 99)) < pct);
                byte_in    = src_bytes[idx];
            end else begin
                byte_valid = 1'b1;
                byte_in    = 8'hEE;
            end
            xfer = byte_valid && byte_ready;
            @(negedge CLK);
            budget--;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check_val("load_done", 64'(done), 64'd1);
        @(negedge CLK);
        check_val("wr_count", 64'(got_q.size()), 64'(nw));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_val("wr_word", got_q[i], exp_q[i]);
        end
        check_val("extra_bytes", 64'(extra), 64'd0);
        check_val("done_state", 64'({done, cpu_hold, busy, byte_ready, error}), 64'b10000);
        if (got_q.size() > 0) begin
            check_val("done_latency", 64'(done_rise_cyc - wr_cyc_q[wr_cyc_q.size()-1]), 64'd1);
        end
        if (nw >= 2 && pct == 100 && wr_cyc_q.size() >= 2) begin
            check_val("throughput", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'(NB + 1));
        end
    endtask

    task automatic reject_start();
        got_q.delete();
        @(negedge CLK);
        start  = 1'b1;
        nwords = (AW+1)'(DEPTH + 1);
        @(negedge CLK);
        start  = 1'b0;
        check_val("reject_err", 64'(error), 64'd1);
        check_val("reject_state", 64'({busy, done, cpu_hold, byte_ready}), 64'b0010);
        repeat (4) @(negedge CLK);
        check_val("reject_nowr", 64'(got_q.size()), 64'd0);
        check_val("reject_hold", 64'({error, cpu_hold, done}), 64'b110);
    endtask

    task automatic zero_load();
        got_q.delete();
        @(negedge CLK);
        start  = 1'b1;
        nwords = '0;
        @(negedge CLK);
        start  = 1'b0;
        check_val("zero_done", 64'({done, cpu_hold, busy}), 64'b100);
        repeat (3) @(negedge CLK);
        check_val("zero_nowr", 64'(got_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] last;
        int          nw;
        int          poke;
        #2 RESET = 1'b1;
        #1 check_reset("reset");
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        reject_start();
        fill_random(1);
        run_load(1, 100, -1, -1);

        src_bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, 100, -1, -1);
        check_val("t1_word0", got_q[0], 64'h0_0000_0013);
        check_val("t1_word1", got_q[1], 64'h1_0010_0093);

        run_load(2, 50, 3, -1);

        reject_start();
        zero_load();

        for (int r = 0; r < 6; r++) begin
            nw   = int'($urandom_range(1, 9));
            poke = -1;
            if (r % 2 == 1) poke = int'($urandom_range(0, nw * NB - 1));
            fill_random(nw);
            run_load(nw, int'($urandom_range(40, 100)), poke, -1);
        end

        fill_random(3);
        run_load(3, 100, -1, 5);
        #2 RESET = 1'b1;
        #1 check_reset("async_reset");
        @(negedge CLK);
        RESET = 1'b0;
        fill_random(3);
        run_load(3, 70, -1, -1);

        fill_random(DEPTH);
        run_load(DEPTH, 100, -1, -1);
        last = got_q[got_q.size()-1];
        check_val("last_addr", 64'(last[WW +: AW]), 64'(DEPTH - 1));

        check_val("ready_wr_overlap", 64'(n_overlap), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
